// File: rtl/ifc_stim_chk.sv
// ifc_stim_chk: drives an incrementing sequence onto ifc.valuei and checks that
// ifc.valueo returns valuei + INC (mod 2^WIDTH) exactly LATENCY cycles later.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request to begin a sequence (IDLE/DONE only)
//   seed            first value driven, sampled with start
//   num_xfers       number of values to drive, sampled with start
//   valuei          registered value to the responder
//   valueo          response from the responder
//   busy            high while driving or draining
//   done            high once the sequence has completed
//   pass            valid with done: no mismatches and all responses matched
//   match_cnt       number of matching responses
//   err_cnt         number of mismatching responses, saturating
//   first_err_idx   0-based index of the first mismatch, 0 if none
module ifc_stim_chk #(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned INC     = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_xfers,
    output logic [WIDTH-1:0] valuei,
    input  logic [WIDTH-1:0] valueo,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int unsigned EXP_W = LATENCY * WIDTH;
    localparam int unsigned IDX_W = LATENCY * CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                          state_q, state_d;
    logic [WIDTH-1:0]                valuei_q, valuei_d;
    logic                            drv_vld_q, drv_vld_d;
    logic [CNT_W-1:0]                drv_idx_q, drv_idx_d;
    logic [CNT_W-1:0]                xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0]                num_q, num_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            pass_q, pass_d;
    logic [CNT_W-1:0]                match_q, match_d;
    logic [CNT_W-1:0]                err_q, err_d;
    logic [CNT_W-1:0]                first_q, first_d;
    logic [LATENCY-1:0]              sl_vld_q, sl_vld_d;
    logic [LATENCY-1:0][WIDTH-1:0]   sl_exp_q, sl_exp_d;
    logic [LATENCY-1:0][CNT_W-1:0]   sl_idx_q, sl_idx_d;
    logic [WIDTH-1:0]                exp_push;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valuei_q   <= '0;
            drv_vld_q  <= 1'b0;
            drv_idx_q  <= '0;
            xfer_cnt_q <= '0;
            num_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            match_q    <= '0;
            err_q      <= '0;
            first_q    <= '0;
            sl_vld_q   <= '0;
            sl_exp_q   <= '0;
            sl_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            valuei_q   <= valuei_d;
            drv_vld_q  <= drv_vld_d;
            drv_idx_q  <= drv_idx_d;
            xfer_cnt_q <= xfer_cnt_d;
            num_q      <= num_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            match_q    <= match_d;
            err_q      <= err_d;
            first_q    <= first_d;
            sl_vld_q   <= sl_vld_d;
            sl_exp_q   <= sl_exp_d;
            sl_idx_q   <= sl_idx_d;
        end
    end

    // Expected response for the value currently on valuei
    assign exp_push = valuei_q + WIDTH'(INC);

    // Next-state, sequence generation and response checking
    always_comb begin
        state_d    = state_q;
        valuei_d   = valuei_q;
        drv_vld_d  = 1'b0;
        drv_idx_d  = drv_idx_q;
        xfer_cnt_d = xfer_cnt_q;
        num_d      = num_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        match_d    = match_q;
        err_d      = err_q;
        first_d    = first_q;

        // The entry describing this cycle's valuei enters at stage 0, so it
        // reaches the last stage exactly when its response is on valueo.
        sl_vld_d = LATENCY'({sl_vld_q, drv_vld_q});
        sl_exp_d = EXP_W'({sl_exp_q, exp_push});
        sl_idx_d = IDX_W'({sl_idx_q, drv_idx_q});

        // Check the oldest entry against the response sampled this cycle
        if (sl_vld_q[LATENCY-1]) begin
            if (sl_exp_q[LATENCY-1] == valueo) begin
                match_d = match_q + CNT_W'(1);
            end else begin
                if (err_q != '1) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (err_q == '0) begin
                    first_d = sl_idx_q[LATENCY-1];
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d   = num_xfers;
                    match_d = '0;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    if (num_xfers == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        valuei_d   = seed;
                        drv_vld_d  = 1'b1;
                        drv_idx_d  = '0;
                        xfer_cnt_d = CNT_W'(1);
                        busy_d     = 1'b1;
                        state_d    = (num_xfers == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                valuei_d   = valuei_q + WIDTH'(1);
                drv_vld_d  = 1'b1;
                drv_idx_d  = xfer_cnt_q;
                xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
                if (xfer_cnt_q + CNT_W'(1) == num_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the last outstanding check is being consumed now
                if (sl_vld_d == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0) && (match_d == num_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign valuei        = valuei_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign match_cnt     = match_q;
    assign err_cnt       = err_q;
    assign first_err_idx = first_q;

endmodule
